// File: rtl/rv32i_lsu_if.sv
// Bundles the LSU request, memory-bus and writeback-response signals.
// The master modport is the LSU's view; slave is the pipeline/memory side.
interface rv32i_lsu_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            req_we;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [4:0]      req_rd;

  logic            mem_req;
  logic            mem_gnt;
  logic [XLEN-1:0] mem_addr;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;
  logic            mem_err;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_rdata;
  logic [4:0]      rsp_rd;
  logic            rsp_we;
  logic            rsp_misaligned;
  logic            rsp_err;

  modport master (
    input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, req_rd,
    output req_ready,
    output mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err,
    output rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_misaligned, rsp_err,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned, req_rd,
    input  req_ready,
    input  mem_req, mem_addr, mem_we, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err,
    input  rsp_valid, rsp_rdata, rsp_rd, rsp_we, rsp_misaligned, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one outstanding access, byte-lane steering on stores,
// lane extraction and sign/zero extension on loads, misalignment detection.
module rv32i_lsu #(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  rv32i_lsu_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e          state_q;
  logic [XLEN-1:0] addr_q;
  logic [1:0]      size_q;
  logic            unsigned_q;
  logic            we_q;
  logic [4:0]      rd_q;

  logic            mem_req_q;
  logic            mem_we_q;
  logic [3:0]      mem_be_q;
  logic [XLEN-1:0] mem_wdata_q;

  logic            rsp_valid_q;
  logic            rsp_misaligned_q;
  logic            rsp_err_q;
  logic [XLEN-1:0] rsp_rdata_q;

  logic            accept;
  logic            acc_misaligned;
  logic [3:0]      acc_be;
  logic [XLEN-1:0] acc_wdata;

  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] data,
                                               input logic [1:0]      off,
                                               input logic [1:0]      size,
                                               input logic            uns);
    logic [XLEN-1:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      2'b00:   load_ext = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      2'b01:   load_ext = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      default: load_ext = data;
    endcase
  endfunction

  assign accept = bus.req_valid & (state_q == S_IDLE);

  // Decode the incoming request so lane steering is ready to register on accept.
  always_comb begin
    acc_misaligned = 1'b0;
    acc_be         = 4'b1111;
    acc_wdata      = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        acc_be    = 4'b0001 << bus.req_addr[1:0];
        acc_wdata = {(XLEN/8){bus.req_wdata[7:0]}};
      end
      2'b01: begin
        acc_misaligned = bus.req_addr[0];
        acc_be         = 4'b0011 << bus.req_addr[1:0];
        acc_wdata      = {(XLEN/16){bus.req_wdata[15:0]}};
      end
      2'b10:   acc_misaligned = (bus.req_addr[1:0] != 2'b00);
      default: acc_misaligned = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= S_IDLE;
      addr_q           <= '0;
      size_q           <= '0;
      unsigned_q       <= 1'b0;
      we_q             <= 1'b0;
      rd_q             <= '0;
      mem_req_q        <= 1'b0;
      mem_we_q         <= 1'b0;
      mem_be_q         <= '0;
      mem_wdata_q      <= '0;
      rsp_valid_q      <= 1'b0;
      rsp_misaligned_q <= 1'b0;
      rsp_err_q        <= 1'b0;
      rsp_rdata_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            addr_q           <= bus.req_addr;
            size_q           <= bus.req_size;
            unsigned_q       <= bus.req_unsigned;
            we_q             <= bus.req_we;
            rd_q             <= bus.req_rd;
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b0;
            rsp_misaligned_q <= acc_misaligned;
            if (acc_misaligned) begin
              // Faulting access never touches the bus.
              state_q     <= S_RESP;
              rsp_valid_q <= 1'b1;
              mem_we_q    <= 1'b0;
              mem_be_q    <= '0;
            end else begin
              state_q     <= S_REQ;
              mem_req_q   <= 1'b1;
              mem_we_q    <= bus.req_we;
              mem_be_q    <= acc_be;
              mem_wdata_q <= acc_wdata;
            end
          end
        end
        S_REQ: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.mem_rvalid) begin
            state_q     <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= bus.mem_err;
            rsp_rdata_q <= (bus.mem_err | we_q) ? '0
                         : load_ext(bus.mem_rdata, addr_q[1:0], size_q, unsigned_q);
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready      = (state_q == S_IDLE);
  assign bus.mem_req        = mem_req_q;
  assign bus.mem_addr       = {addr_q[XLEN-1:2], 2'b00};
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_be         = mem_be_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.rsp_rd         = rd_q;
  assign bus.rsp_we         = we_q;
  assign bus.rsp_misaligned = rsp_misaligned_q;
  assign bus.rsp_err        = rsp_err_q;

endmodule
